buttons_debounce: RTL and testbench
===================================

# buttons_debounce

Memory-mapped button input peripheral on the SoC common memory bus, replacing the raw `buttons` read path at 0x00010004 with a 16-byte window. It synchronises the asynchronous button pins and debounces each bit. It also latches sticky rising/falling edge flags and counts press events, so firmware polling at low rates never misses a press. Bus behaviour is zero-wait-state and OR-combined like every other slave on the bus.

## Interface
- `BUTTONCOUNT`, 4, number of button inputs, legal 1..8
- `DEBOUNCE_CYCLES`, 50000, consecutive stable synchronised cycles required to accept a new level, legal 1..65535

- `clk` in 1 — system clock
- `reset` in 1 — asynchronous, active-high reset
- `buttons_in` in BUTTONCOUNT — raw asynchronous button pins
- `address_in` in 32 — bus address; only [3:2] decoded
- `sel_in` in 1 — window select from top-level decoder
- `read_in` in 1 — bus read strobe (unused for side effects; reads have none)
- `read_value_out` out 32 — read data, 0 when `sel_in`=0
- `write_mask_in` in 4 — byte write enables; only bit 0 acts
- `write_value_in` in 32 — write data
- `ready_out` out 1 — equals `sel_in`

## Operation
- Synchroniser: two flops per bit, reset to 0; output `sync`.
- Debounce per bit: counter width 16. If `sync`==`stable`, counter <= 0. Otherwise counter increments. When counter == DEBOUNCE_CYCLES-1 and `sync`!=`stable`, `stable` <= `sync` and counter <= 0.
- Edge detect on `stable` transitions: 0→1 sets RISE[i]; 1→0 sets FALL[i].
- Register map (offset = address_in[3:2]):
  - 0x0 STATE, RO: {0, stable}
  - 0x4 RISE, W1C with mask[0]: sticky rising flags
  - 0x8 FALL, W1C with mask[0]: sticky falling flags
  - 0xC EVENTS, RW: 16-bit count of cycles in which ≥1 bit rose. Any write with mask[0] clears it to 0.
- Unused upper bits read 0. Writes to STATE are ignored. Writes with mask[0]=0 have no effect.
- Simultaneous set and W1C of the same flag: set wins, flag stays 1.
- Simultaneous increment and clear of EVENTS: result 1.
- EVENTS wraps 0xFFFF→0x0000. Multiple bits rising in one cycle count as 1.
- Reset: all flops, `stable`, counters, RISE, FALL and EVENTS go to 0. No edge is flagged when reset deasserts. A button held at reset release is reported as a rise once debounced.

## Timing
- `read_value_out`, `ready_out`: combinational from `sel_in`/`address_in`/registers. Zero wait states; read returns the pre-edge register value.
- Writes take effect at the rising edge where `sel_in`=1.
- Input level change to `stable` update: DEBOUNCE_CYCLES+2 rising edges (2 synchroniser, DEBOUNCE_CYCLES counter). RISE/FALL/EVENTS update on the same edge as `stable`.
- A pulse whose synchronised width is shorter than DEBOUNCE_CYCLES cycles never changes `stable`.
- Asynchronous reset mid-debounce: counters drop to 0 immediately. Outputs are 0 while `reset`=1.

## Configuration
- `BUTTONS_DEBOUNCE_EN` defined: debounce counters present as above.
- Undefined: no counters; `stable` <= `sync` every cycle. Latency is 2 edges and glitches are not filtered. Register map and edge logic are unchanged, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset with buttons_in=4'b0101, DEBOUNCE_CYCLES=4 → all reads 0 during reset. After release, STATE=0x5 at edge 6, RISE=0x5, EVENTS=1.
- buttons_in[1] pulse of 3 cycles, DEBOUNCE_CYCLES=4 → STATE, RISE and EVENTS unchanged.
- buttons_in[2] 0→1 held → STATE[2]=1 exactly 6 edges later. Write RISE=0x4 → RISE=0. Release → FALL=0x4 after 6 edges.
- Write RISE=0x1 in the same cycle bit 0 rises → RISE[0] remains 1.
- Preload EVENTS via 65535 presses (or forced) at 0xFFFF, one more press → EVENTS=0. Write EVENTS with mask=4'b0000 → unchanged. Mask=4'b0001 → 0.
- sel_in=0 with any address → read_value_out=0, ready_out=0. Writes are ignored.

Source files
------------

// File: rtl/buttons_debounce.sv
// buttons_debounce: synchronised, debounced button peripheral with sticky edge flags and a press counter.
// Define BUTTONS_DEBOUNCE_EN to build the debounce counters; otherwise the synchroniser output feeds edge logic directly.
module buttons_debounce #(
  parameter int BUTTONCOUNT     = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  input  logic [31:0]            address_in,
  input  logic                   sel_in,
  input  logic                   read_in,
  output logic [31:0]            read_value_out,
  input  logic [3:0]             write_mask_in,
  input  logic [31:0]            write_value_in,
  output logic                   ready_out
);
  logic [BUTTONCOUNT-1:0] meta_q, stable_q, stable_d, rise_q, rise_d, fall_q, fall_d;
  logic [BUTTONCOUNT-1:0] rise_set, fall_set, rise_clr, fall_clr;
  logic [15:0]            events_q, events_d;
  logic [1:0]             addr;
  logic                   we, inc, unused_ok;

  assign addr = address_in[3:2];
  assign we   = sel_in & write_mask_in[0];

`ifdef BUTTONS_DEBOUNCE_EN
  localparam logic [15:0] DC_MAX = 16'(DEBOUNCE_CYCLES - 1);
  logic [BUTTONCOUNT-1:0] sync_q;
  logic [15:0]            cnt_q [BUTTONCOUNT];
  logic [15:0]            cnt_d [BUTTONCOUNT];

  // a new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < BUTTONCOUNT; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DC_MAX) stable_d[i] = sync_q[i];
        else cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      for (int i = 0; i < BUTTONCOUNT; i++) cnt_q[i] <= '0;
    end else begin
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  assign unused_ok = ^{read_in, address_in[31:4], address_in[1:0], write_mask_in[3:1],
                       write_value_in};
`else
  // the second synchroniser stage is stable itself, giving a two-edge latency
  assign stable_d  = meta_q;
  assign unused_ok = ^{read_in, address_in[31:4], address_in[1:0], write_mask_in[3:1],
                       write_value_in, 32'(DEBOUNCE_CYCLES)};
`endif

  assign rise_set = stable_d & ~stable_q;
  assign fall_set = ~stable_d & stable_q;
  assign inc      = |rise_set;
  assign rise_clr = (we && addr == 2'd1) ? write_value_in[BUTTONCOUNT-1:0] : '0;
  assign fall_clr = (we && addr == 2'd2) ? write_value_in[BUTTONCOUNT-1:0] : '0;

  always_comb begin
    rise_d   = (rise_q & ~rise_clr) | rise_set;
    fall_d   = (fall_q & ~fall_clr) | fall_set;
    events_d = (we && addr == 2'd3) ? {15'd0, inc} : events_q + {15'd0, inc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      events_q <= '0;
    end else begin
      meta_q   <= buttons_in;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      events_q <= events_d;
    end
  end

  assign ready_out      = sel_in;
  assign read_value_out = !sel_in       ? 32'd0 :
                          addr == 2'd0  ? 32'(stable_q) :
                          addr == 2'd1  ? 32'(rise_q) :
                          addr == 2'd2  ? 32'(fall_q) : 32'(events_q);
endmodule

// File: tb/tb_buttons_debounce.sv
// tb_buttons_debounce: vector table plus scripted sequences, with a queue of expected register reads.
module tb_buttons_debounce;
  localparam int BC = 4;
  localparam int DC = 4;
`ifdef BUTTONS_DEBOUNCE_EN
  localparam int LAT = DC + 2;
`else
  localparam int LAT = 2;
`endif

  logic          clk, reset, sel_in, read_in, ready_out;
  logic [BC-1:0] buttons_in;
  logic [31:0]   address_in, read_value_out, write_value_in;
  logic [3:0]    write_mask_in;

  int checks = 0, failures = 0;

  typedef struct {
    string       name;
    logic [1:0]  a;
    logic [31:0] v;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  a;
    logic [3:0]  m;
    logic [31:0] w;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[7];

  buttons_debounce #(.BUTTONCOUNT(BC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .buttons_in(buttons_in), .address_in(address_in),
    .sel_in(sel_in), .read_in(read_in), .read_value_out(read_value_out),
    .write_mask_in(write_mask_in), .write_value_in(write_value_in), .ready_out(ready_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_rd(input logic [1:0] a, input logic [31:0] v, input string name);
    exp_t e;
    e.name = name;
    e.a = a;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sel_in = 1;
      read_in = 1;
      write_mask_in = 0;
      address_in = {28'd0, e.a, 2'b00};
      #1;
      chk(e.name, read_value_out, e.v);
      sel_in = 0;
      read_in = 0;
    end
  endtask

  task automatic wr(input logic sel, input logic [1:0] a, input logic [3:0] m, input logic [31:0] w);
    sel_in = sel;
    address_in = {28'd0, a, 2'b00};
    write_mask_in = m;
    write_value_in = w;
    step(1);
    sel_in = 0;
    write_mask_in = 0;
    write_value_in = 0;
  endtask

  initial begin
    // state entering the table: stable=5 rise=5 fall=0 events=1
    tbl[0] = '{"state_ro",    1'b1, 2'd0, 4'h1, 32'hFFFF_FFFF, 32'h5};
    tbl[1] = '{"rise_mask0",  1'b1, 2'd1, 4'hE, 32'hFFFF_FFFF, 32'h5};
    tbl[2] = '{"rise_nosel",  1'b0, 2'd1, 4'h1, 32'hFFFF_FFFF, 32'h5};
    tbl[3] = '{"rise_w1c_b0", 1'b1, 2'd1, 4'h1, 32'h1,         32'h4};
    tbl[4] = '{"ev_mask0",    1'b1, 2'd3, 4'h0, 32'h0,         32'h1};
    tbl[5] = '{"ev_clear",    1'b1, 2'd3, 4'h1, 32'h0,         32'h0};
    tbl[6] = '{"rise_w1c_all",1'b1, 2'd1, 4'h1, 32'hFFFF_FFFF, 32'h0};

    reset = 1; buttons_in = 4'b0101; sel_in = 0; read_in = 0;
    address_in = 0; write_mask_in = 0; write_value_in = 0;
    step(3);
    expect_rd(0, 0, "rst_state"); expect_rd(1, 0, "rst_rise");
    expect_rd(2, 0, "rst_fall");  expect_rd(3, 0, "rst_events");
    drain();
    reset = 0;
    step(LAT - 1);
    expect_rd(0, 0, "held_state_early");
    drain();
    step(1);
    expect_rd(0, 5, "held_state"); expect_rd(1, 5, "held_rise");
    expect_rd(2, 0, "held_fall");  expect_rd(3, 1, "held_events");
    drain();

    for (int i = 0; i < 7; i++) begin
      wr(tbl[i].sel, tbl[i].a, tbl[i].m, tbl[i].w);
      expect_rd(tbl[i].a, tbl[i].exp, tbl[i].name);
      drain();
    end

    for (int i = 0; i < 4; i++) begin
      sel_in = 0;
      address_in = i << 2;
      #1;
      chk("nosel_read", read_value_out, 0);
      chk("nosel_ready", {31'd0, ready_out}, 0);
    end
    sel_in = 1;
    #1;
    chk("sel_ready", {31'd0, ready_out}, 1);
    sel_in = 0;
    step(1);

    // three-cycle glitch on bit 1
    buttons_in = 4'b0111;
    step(3);
    buttons_in = 4'b0101;
    step(LAT + 4);
    expect_rd(0, 5, "glitch_state");
`ifdef BUTTONS_DEBOUNCE_EN
    expect_rd(1, 0, "glitch_rise"); expect_rd(3, 0, "glitch_events");
`else
    expect_rd(1, 2, "glitch_rise"); expect_rd(2, 2, "glitch_fall");
    expect_rd(3, 1, "glitch_events");
`endif
    drain();
    wr(1, 1, 4'h1, 32'hF); wr(1, 2, 4'h1, 32'hF); wr(1, 3, 4'h1, 0);

    buttons_in = 4'b0000;
    step(LAT);
    expect_rd(0, 0, "release_state"); expect_rd(2, 5, "release_fall");
    drain();
    wr(1, 2, 4'h1, 32'hF);

    buttons_in = 4'b0100;
    step(LAT - 1);
    expect_rd(0, 0, "b2_state_early");
    drain();
    step(1);
    expect_rd(0, 4, "b2_state"); expect_rd(1, 4, "b2_rise"); expect_rd(3, 1, "b2_events");
    drain();
    wr(1, 1, 4'h1, 32'h4);
    expect_rd(1, 0, "b2_rise_w1c");
    drain();
    buttons_in = 4'b0000;
    step(LAT - 1);
    expect_rd(2, 0, "b2_fall_early");
    drain();
    step(1);
    expect_rd(2, 4, "b2_fall");
    drain();

    // W1C lands on the same edge bit 0 rises
    buttons_in = 4'b0001;
    step(LAT - 1);
    wr(1, 1, 4'h1, 32'h1);
    expect_rd(1, 1, "set_beats_w1c"); expect_rd(0, 1, "b0_state"); expect_rd(3, 2, "b0_events");
    drain();
    buttons_in = 4'b0000;
    step(LAT);
    expect_rd(2, 5, "b0_fall");
    drain();
    // EVENTS clear lands on the same edge as a rise
    buttons_in = 4'b0001;
    step(LAT - 1);
    wr(1, 3, 4'h1, 0);
    expect_rd(3, 1, "inc_beats_clear");
    drain();
    buttons_in = 4'b0000;
    step(LAT);

    force dut.events_q = 16'hFFFF;
    #1;
    release dut.events_q;
    expect_rd(3, 32'hFFFF, "ev_preload");
    drain();
    buttons_in = 4'b0010;
    step(LAT);
    expect_rd(3, 0, "ev_wrap");
    drain();
    buttons_in = 4'b0000;
    step(LAT);
    buttons_in = 4'b1000;
    step(LAT);
    expect_rd(3, 1, "ev_after_wrap");
    drain();
    wr(1, 3, 4'h0, 0);
    expect_rd(3, 1, "ev_wr_mask0");
    drain();
    wr(1, 3, 4'h1, 0);
    expect_rd(3, 0, "ev_wr_mask1");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
